seven_seg_scan_driver: RTL and testbench

Multiplexed, brightness-controlled driver for the board's 4-digit common-anode seven-segment display, sitting directly downstream of the clock timekeeping core. It takes four BCD digits plus decimal points from the clock core and scans them one digit at a time onto the shared segment bus. A 2-bit brightness input PWMs each digit's on-time. Both display buses are registered and active-low.

---
 rtl/seven_seg_scan_driver.sv | 113 +++++++++++
 tb/tb_seven_seg_scan_driver.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver: scans four BCD digits (+DP) onto a shared active-low
// segment bus with a 2-bit PWM brightness; one registered output stage (1 cycle).
// No backpressure. Optional macro LEADING_ZERO_BLANK_EN blanks a leading zero on digit 3.
module seven_seg_scan_driver #(
   parameter int SLOT_BITS = 16
) (
   input  logic        Clk_100M,
   input  logic        Reset_n,
   input  logic [15:0] Digits,
   input  logic [3:0]  DecimalPoints,
   input  logic [1:0]  Brightness,
   output logic [3:0]  SegmentDrivers,
   output logic [7:0]  SevenSegment
);

   logic [SLOT_BITS-1:0] cnt_q, cnt_d;
   logic [1:0]           idx_q, idx_d;
   logic [15:0]          sh_dig_q, sh_dig_d;
   logic [3:0]           sh_dp_q, sh_dp_d;
   logic [1:0]           sh_bri_q, sh_bri_d;
   logic [3:0]           an_q, an_d;
   logic [7:0]           seg_q, seg_d;

   logic                 slot_wrap;
   logic                 frame_capture;
   logic [1:0]           phase;
   logic [3:0]           cur_dig;
   logic [6:0]           glyph;
   logic                 digit_en;

   // Scan counters advance every cycle; shadow copies of the inputs are only
   // refreshed on the last cycle of a frame so a frame never shows mixed data.
   always_comb begin
      slot_wrap     = &cnt_q;
      frame_capture = slot_wrap && (idx_q == 2'd3);
      cnt_d         = cnt_q + {{(SLOT_BITS-1){1'b0}}, 1'b1};
      idx_d         = idx_q;
      sh_dig_d      = sh_dig_q;
      sh_dp_d       = sh_dp_q;
      sh_bri_d      = sh_bri_q;
      if (slot_wrap) begin
         idx_d = idx_q + 2'd1;
      end
      if (frame_capture) begin
         sh_dig_d = Digits;
         sh_dp_d  = DecimalPoints;
         sh_bri_d = Brightness;
      end
   end

   // Decode the current shadow digit into an active-low g..a glyph.
   always_comb begin
      cur_dig = sh_dig_q[{idx_q, 2'b00} +: 4];
      glyph   = 7'b1111111;
      case (cur_dig)
         4'd0:    glyph = 7'b1000000;
         4'd1:    glyph = 7'b1111001;
         4'd2:    glyph = 7'b0100100;
         4'd3:    glyph = 7'b0110000;
         4'd4:    glyph = 7'b0011001;
         4'd5:    glyph = 7'b0010010;
         4'd6:    glyph = 7'b0000010;
         4'd7:    glyph = 7'b1111000;
         4'd8:    glyph = 7'b0000000;
         4'd9:    glyph = 7'b0010000;
         default: glyph = 7'b1111111;
      endcase
`ifdef LEADING_ZERO_BLANK_EN
      // Only the leftmost digit is blanked; its DP and anode timing are untouched.
      if ((idx_q == 2'd3) && (cur_dig == 4'd0)) begin
         glyph = 7'b1111111;
      end
`else
`endif
   end

   // PWM gate: the digit is lit for the first (Brightness+1) quarters of its slot.
   always_comb begin
      phase    = cnt_q[SLOT_BITS-1 -: 2];
      digit_en = (phase <= sh_bri_q);
      an_d     = 4'hF;
      seg_d    = 8'hFF;
      if (digit_en) begin
         an_d  = ~(4'b0001 << idx_q);
         seg_d = {~sh_dp_q[idx_q], glyph};
      end
   end

   // State and registered outputs; reset darkens the display immediately.
   always_ff @(posedge Clk_100M or negedge Reset_n) begin
      if (!Reset_n) begin
         cnt_q    <= '0;
         idx_q    <= 2'd0;
         sh_dig_q <= 16'h0000;
         sh_dp_q  <= 4'h0;
         sh_bri_q <= 2'd0;
         an_q     <= 4'hF;
         seg_q    <= 8'hFF;
      end else begin
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         sh_dig_q <= sh_dig_d;
         sh_dp_q  <= sh_dp_d;
         sh_bri_q <= sh_bri_d;
         an_q     <= an_d;
         seg_q    <= seg_d;
      end
   end

   assign SegmentDrivers = an_q;
   assign SevenSegment   = seg_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// tb_seven_seg_scan_driver: frame-by-frame scoreboard for the scan driver at
// SLOT_BITS=4 (16-cycle slots, 64-cycle frames); expected outputs are queued
// per frame and compared every cycle on the falling clock edge.
module tb_seven_seg_scan_driver;

   localparam int SB = 4;

   logic        Clk_100M;
   logic        Reset_n;
   logic [15:0] Digits;
   logic [3:0]  DecimalPoints;
   logic [1:0]  Brightness;
   logic [3:0]  SegmentDrivers;
   logic [7:0]  SevenSegment;

   typedef struct {
      logic [3:0] an;
      logic [7:0] seg;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec  = 0;
   int   n_fail = 0;

   seven_seg_scan_driver #(.SLOT_BITS(SB)) dut (
      .Clk_100M       (Clk_100M),
      .Reset_n        (Reset_n),
      .Digits         (Digits),
      .DecimalPoints  (DecimalPoints),
      .Brightness     (Brightness),
      .SegmentDrivers (SegmentDrivers),
      .SevenSegment   (SevenSegment)
   );

   initial Clk_100M = 1'b0;
   always #5 Clk_100M = ~Clk_100M;

   task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, act, exp);
      end
   endtask

   // Reference glyph table, active-low g..a.
   function automatic logic [6:0] ref_glyph(input logic [3:0] d, input int pos);
      logic [6:0] g;
      case (d)
         4'd0: g = 7'b1000000;
         4'd1: g = 7'b1111001;
         4'd2: g = 7'b0100100;
         4'd3: g = 7'b0110000;
         4'd4: g = 7'b0011001;
         4'd5: g = 7'b0010010;
         4'd6: g = 7'b0000010;
         4'd7: g = 7'b1111000;
         4'd8: g = 7'b0000000;
         4'd9: g = 7'b0010000;
         default: g = 7'b1111111;
      endcase
`ifdef LEADING_ZERO_BLANK_EN
      if (pos == 3 && d == 4'd0) g = 7'b1111111;
`else
      if (pos > 3) g = 7'b1111111;
`endif
      return g;
   endfunction

   // Entered just before the first output edge of a frame. Queues the 64
   // expected output cycles for the displayed values, then checks them.
   // Optionally changes Digits mid-frame, and loads the next frame's inputs
   // before the capture edge (last edge of the frame).
   task automatic run_frame(input string name,
                            input logic [15:0] e_dig, input logic [3:0] e_dp,
                            input logic [1:0] e_br,
                            input bit mid_en, input logic [15:0] mid_dig,
                            input logic [15:0] n_dig, input logic [3:0] n_dp,
                            input logic [1:0] n_br);
      exp_t e;
      exp_t o;
      for (int i = 0; i < 64; i++) begin
         int  slot;
         int  k;
         bit  en;
         slot  = i / 16;
         k     = i % 16;
         en    = ((k / 4) <= int'(e_br));
         e.an  = en ? ~(4'b0001 << slot) : 4'hF;
         e.seg = en ? {~e_dp[slot], ref_glyph(e_dig[slot*4 +: 4], slot)} : 8'hFF;
         exp_q.push_back(e);
      end
      for (int i = 0; i < 64; i++) begin
         @(posedge Clk_100M);
         @(negedge Clk_100M);
         if (exp_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL %s: scoreboard empty at cycle %0d", name, i);
         end else begin
            o = exp_q.pop_front();
            check($sformatf("%s an c%0d", name, i), {4'h0, SegmentDrivers}, {4'h0, o.an});
            check($sformatf("%s seg c%0d", name, i), SevenSegment, o.seg);
         end
         if (mid_en && i == 30) Digits = mid_dig;
         if (i == 62) begin
            Digits        = n_dig;
            DecimalPoints = n_dp;
            Brightness    = n_br;
         end
      end
   endtask

   initial begin
      Reset_n       = 1'b0;
      Digits        = 16'h1234;
      DecimalPoints = 4'b0001;
      Brightness    = 2'b11;
      repeat (3) @(negedge Clk_100M);
      check("reset an", {4'h0, SegmentDrivers}, 8'h0F);
      check("reset seg", SevenSegment, 8'hFF);
      Reset_n = 1'b1;

      // Reset shadow is shown first regardless of the inputs.
      run_frame("rst0",  16'h0000, 4'b0000, 2'b00, 1'b0, 16'h0, 16'h1234, 4'b0001, 2'b11);
      run_frame("full",  16'h1234, 4'b0001, 2'b11, 1'b0, 16'h0, 16'h1234, 4'b0001, 2'b00);
      run_frame("duty0", 16'h1234, 4'b0001, 2'b00, 1'b0, 16'h0, 16'h1234, 4'b0000, 2'b01);
      run_frame("duty1", 16'h1234, 4'b0000, 2'b01, 1'b0, 16'h0, 16'h1234, 4'b0000, 2'b10);
      run_frame("duty2", 16'h1234, 4'b0000, 2'b10, 1'b0, 16'h0, 16'hFA09, 4'b1100, 2'b11);
      run_frame("bcd",   16'hFA09, 4'b1100, 2'b11, 1'b0, 16'h0, 16'h1234, 4'b0000, 2'b11);
      run_frame("tear",  16'h1234, 4'b0000, 2'b11, 1'b1, 16'h5678, 16'h5678, 4'b0000, 2'b11);
      run_frame("post",  16'h5678, 4'b0000, 2'b11, 1'b0, 16'h0, 16'h0945, 4'b1000, 2'b11);
      run_frame("lzb",   16'h0945, 4'b1000, 2'b11, 1'b0, 16'h0, 16'h0945, 4'b1000, 2'b11);

      // Mid-slot reset: slot 1 (digit 4, no DP) is lit, then goes dark at once.
      repeat (20) begin
         @(posedge Clk_100M);
         @(negedge Clk_100M);
      end
      check("pre-rst an", {4'h0, SegmentDrivers}, 8'h0D);
      check("pre-rst seg", SevenSegment, 8'h99);
      #2 Reset_n = 1'b0;
      #1;
      check("async rst an", {4'h0, SegmentDrivers}, 8'h0F);
      check("async rst seg", SevenSegment, 8'hFF);
      @(negedge Clk_100M);
      Reset_n = 1'b1;
      run_frame("rst1",  16'h0000, 4'b0000, 2'b00, 1'b0, 16'h0, 16'h0945, 4'b1000, 2'b11);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
